lifo_drain_engine: RTL and testbench
====================================

Name: lifo_drain_engine

Overview:
- Read-side engine for the team's stack: pops entries from a LIFO (pointer controller plus register file) and streams them out over a valid/ready master interface, newest entry first.
- Started by a command pulse. Drains either a fixed count or until the stack is empty.
- Reports completion, the number of words transferred, and underrun.
- Sits between the LIFO storage and any downstream consumer.

Parameters:
- addr_width, 4, LIFO address width; stack depth is 2**addr_width.
- data_width, 8, width of one stack entry.

Ports:
- clk  in  1  clock, rising edge.
- reset_tmp  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle command pulse; accepted only in IDLE.
- count  in  addr_width+1  words to drain, sampled on start; 0 = drain until empty.
- lifo_empty  in  1  empty flag from the LIFO controller (registered).
- lifo_rd_data  in  data_width  register-file word at the current top of stack (combinational read).
- lifo_pop  out  1  pop request to the LIFO controller, one cycle per word.
- m_data  out  data_width  output word, registered.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the word.
- m_last  out  1  final word of a counted drain; always 0 in until-empty mode.
- busy  out  1  high from start accept until done.
- done  out  1  one-cycle completion pulse.
- underrun  out  1  counted drain ended early because the LIFO went empty; held until next start.
- drained_count  out  addr_width+1  words handshaken in the last or current drain; held until next start.

Behaviour:
- Reset (async, reset_tmp=1):
  - state=IDLE.
  - lifo_pop, m_valid, m_last, busy, done, underrun = 0.
  - m_data = 0, drained_count = 0.
  - Reset mid-drain aborts immediately. The word in m_data is lost; words already popped are not restored.
- States: IDLE, LOAD, HOLD, FINISH.
- IDLE:
  - On start=1: latch count into cnt_reg, clear drained_count and underrun, set busy=1, go to LOAD.
  - start in any other state is ignored.
- LOAD (sample lifo_empty):
  - lifo_empty=1 → FINISH; underrun=1 if cnt_reg!=0.
  - Otherwise:
    - m_data<=lifo_rd_data and m_valid<=1.
    - lifo_pop=1 for this cycle.
    - m_last<=1 if cnt_reg!=0 and drained_count==cnt_reg-1.
    - Go to HOLD.
- HOLD (word presented):
  - m_data, m_valid and m_last stay stable while m_ready=0.
  - On handshake (m_valid & m_ready), drained_count increments, then:
    - Counted mode with drained_count+1==cnt_reg → m_valid<=0 and m_last<=0, go to FINISH.
    - Otherwise, if lifo_empty=1 → m_valid<=0, go to FINISH; underrun=1 if counted.
    - Otherwise (back-to-back reload) → load lifo_rd_data, assert lifo_pop, stay in HOLD, update m_last.
  - The pop from the previous cycle has already moved the controller pointer, so lifo_rd_data is the new top.
- FINISH: done=1 for exactly one cycle, busy<=0, go to IDLE.
- Latency and throughput:
  - First m_valid appears 2 cycles after start.
  - Sustained rate is 1 word/cycle with m_ready held high.
- lifo_pop is never asserted while lifo_empty=1, and never more than once per handshaken word.
- External pushes during a drain are permitted. lifo_empty and lifo_rd_data are resampled at every load, so pushed words are drained LIFO-correctly.
- Width rules:
  - count=2**addr_width is legal (full-stack drain).
  - drained_count never wraps, because a drain cannot exceed the stack depth without underrun or empty.

Decomposition:
- Shared package lifo_pkg:
  - typedef enum logic [1:0] drain_state_t {IDLE, LOAD, HOLD, FINISH}.
  - Default constants LIFO_ADDR_WIDTH=4 and LIFO_DATA_WIDTH=8, shared with the LIFO controller.
- Single module; no sub-module. The output register and FSM are small enough to stay flat.

Test Plan (addr_width=4, data_width=8):
- Push 0x11,0x22,0x33; start, count=3, m_ready=1 → m_data 0x33,0x22,0x11 on consecutive cycles; m_last with 0x11; done 1 cycle later; drained_count=3; underrun=0; lifo_empty=1.
- Push 0xA0,0xA1; start, count=0 → 0xA1,0xA0; m_last never asserted; done pulses; drained_count=2; underrun=0.
- Push 0x05; start, count=4 → one word 0x05; done; underrun=1; drained_count=1; lifo_pop asserted exactly once.
- Push 0x01..0x04; start, count=2; m_ready low for 3 cycles on the first word → 0x04 held stable with one lifo_pop only; then 0x03 with m_last; 0x02,0x01 remain in the stack.
- Empty stack; start, count=0 → no m_valid, no lifo_pop; done in cycle 2; drained_count=0; underrun=0; start while busy ignored.
- Fill 16 entries; start, count=16; assert reset_tmp after the 5th handshake → all outputs return to reset values asynchronously; IDLE; a new start is accepted normally.

Source files
------------

// File: rtl/lifo_pkg.sv
// Types and default widths shared by the LIFO controller and its drain engine.
package lifo_pkg;

    localparam int LIFO_ADDR_WIDTH = 4;
    localparam int LIFO_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        HOLD   = 2'd2,
        FINISH = 2'd3
    } drain_state_t;

endpackage

// File: rtl/lifo_drain_engine.sv
// Pops LIFO entries newest-first onto a valid/ready stream; first m_valid 2 cycles after start, 1 word/cycle.
// Backpressure: m_data/m_valid/m_last hold while m_ready is low and no pop is issued until the word is taken.
module lifo_drain_engine
    import lifo_pkg::*;
#(
    parameter int addr_width = LIFO_ADDR_WIDTH,
    parameter int data_width = LIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_tmp,
    input  logic                  start,
    input  logic [addr_width:0]   count,
    input  logic                  lifo_empty,
    input  logic [data_width-1:0] lifo_rd_data,
    output logic                  lifo_pop,
    output logic [data_width-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun,
    output logic [addr_width:0]   drained_count
);

    drain_state_t          state_q, state_d;
    logic [addr_width:0]   cnt_q, cnt_d;
    logic [addr_width:0]   drained_q, drained_d;
    logic [data_width-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic                  busy_q, busy_d;
    logic                  underrun_q, underrun_d;

    logic                  counted;
    logic [addr_width:0]   cnt_m1;
    logic [addr_width:0]   drained_inc;

    assign counted     = (cnt_q != '0);
    assign cnt_m1      = cnt_q - 1'b1;
    assign drained_inc = drained_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drained_d  = drained_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        busy_d     = busy_q;
        underrun_d = underrun_q;
        lifo_pop   = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d      = count;
                    drained_d  = '0;
                    underrun_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (lifo_empty) begin
                    underrun_d = counted;
                    state_d    = FINISH;
                end else begin
                    m_data_d  = lifo_rd_data;
                    m_valid_d = 1'b1;
                    m_last_d  = counted && (drained_q == cnt_m1);
                    lifo_pop  = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (m_valid_q && m_ready) begin
                    drained_d = drained_inc;
                    if (counted && (drained_inc == cnt_q)) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        state_d   = FINISH;
                    end else if (lifo_empty) begin
                        m_valid_d  = 1'b0;
                        m_last_d   = 1'b0;
                        underrun_d = counted;
                        state_d    = FINISH;
                    end else begin
                        // Last cycle's pop already advanced the pointer: rd_data is the new top.
                        m_data_d = lifo_rd_data;
                        m_last_d = counted && (drained_inc == cnt_m1);
                        lifo_pop = 1'b1;
                    end
                end
            end
            FINISH: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_tmp) begin
        if (reset_tmp) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            drained_q  <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drained_q  <= drained_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
        end
    end

    assign m_data        = m_data_q;
    assign m_valid       = m_valid_q;
    assign m_last        = m_last_q;
    assign busy          = busy_q;
    assign underrun      = underrun_q;
    assign drained_count = drained_q;

endmodule

// File: tb/tb_lifo_drain_engine.sv
// Directed bench for lifo_drain_engine against a behavioural 16-entry stack.
module tb_lifo_drain_engine;

    logic       clk;
    logic       reset_tmp;
    logic       start;
    logic [4:0] count;
    logic       lifo_empty;
    logic [7:0] lifo_rd_data;
    logic       lifo_pop;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       busy;
    logic       done;
    logic       underrun;
    logic [4:0] drained_count;

    logic       push_en;
    logic [7:0] push_dat;
    logic [7:0] mem [16];
    logic [4:0] sp;
    logic [3:0] top_idx;
    int         pop_cnt;
    int         bad_pops;
    int         p0;

    int vectors;
    int miscompares;

    lifo_drain_engine dut (
        .clk           (clk),
        .reset_tmp     (reset_tmp),
        .start         (start),
        .count         (count),
        .lifo_empty    (lifo_empty),
        .lifo_rd_data  (lifo_rd_data),
        .lifo_pop      (lifo_pop),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .busy          (busy),
        .done          (done),
        .underrun      (underrun),
        .drained_count (drained_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stack model: registered pointer, so empty is a registered flag; combinational top read.
    assign top_idx      = sp[3:0] - 4'd1;
    assign lifo_empty   = (sp == 5'd0);
    assign lifo_rd_data = mem[top_idx];

    initial begin
        sp       = 5'd0;
        pop_cnt  = 0;
        bad_pops = 0;
    end

    always @(posedge clk) begin
        if (lifo_pop) begin
            pop_cnt <= pop_cnt + 1;
            if (sp == 5'd0) bad_pops <= bad_pops + 1;
        end
        if (push_en && lifo_pop) begin
            mem[top_idx] <= push_dat;
        end else if (push_en) begin
            mem[sp[3:0]] <= push_dat;
            sp           <= sp + 5'd1;
        end else if (lifo_pop) begin
            sp <= sp - 5'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [7:0] exp_data, input logic exp_last);
        chk({tag, " valid"}, {31'd0, m_valid}, 32'd1);
        chk({tag, " data"}, {24'd0, m_data}, {24'd0, exp_data});
        chk({tag, " last"}, {31'd0, m_last}, {31'd0, exp_last});
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        push_en  = 1'b1;
        push_dat = d;
        @(posedge clk);
        #1 push_en = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " pop"}, {31'd0, lifo_pop}, 32'd0);
        chk({tag, " valid"}, {31'd0, m_valid}, 32'd0);
        chk({tag, " last"}, {31'd0, m_last}, 32'd0);
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " done"}, {31'd0, done}, 32'd0);
        chk({tag, " underrun"}, {31'd0, underrun}, 32'd0);
        chk({tag, " data"}, {24'd0, m_data}, 32'd0);
        chk({tag, " drained"}, {27'd0, drained_count}, 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_tmp   = 1'b1;
        start       = 1'b0;
        count       = 5'd0;
        m_ready     = 1'b0;
        push_en     = 1'b0;
        push_dat    = 8'd0;
        #1;
        chk_idle_outputs("reset");
        repeat (2) @(negedge clk);
        reset_tmp = 1'b0;

        // Counted drain of 3, ready always high
        push(8'h11); push(8'h22); push(8'h33);
        p0 = pop_cnt;
        @(negedge clk); start = 1'b1; count = 5'd3; m_ready = 1'b1;
        #1 chk("t1 busy before accept", {31'd0, busy}, 32'd0);
        @(negedge clk); start = 1'b0;
        #1 chk("t1 load pop", {31'd0, lifo_pop}, 32'd1);
        chk("t1 load valid", {31'd0, m_valid}, 32'd0);
        chk("t1 load busy", {31'd0, busy}, 32'd1);
        @(negedge clk); #1 chk_word("t1 w0", 8'h33, 1'b0);
        chk("t1 w0 pop", {31'd0, lifo_pop}, 32'd1);
        @(negedge clk); #1 chk_word("t1 w1", 8'h22, 1'b0);
        @(negedge clk); #1 chk_word("t1 w2", 8'h11, 1'b1);
        chk("t1 w2 pop", {31'd0, lifo_pop}, 32'd0);
        @(negedge clk); #1 chk("t1 done", {31'd0, done}, 32'd1);
        chk("t1 fin valid", {31'd0, m_valid}, 32'd0);
        chk("t1 drained", {27'd0, drained_count}, 32'd3);
        chk("t1 underrun", {31'd0, underrun}, 32'd0);
        @(negedge clk); #1 chk("t1 done gone", {31'd0, done}, 32'd0);
        chk("t1 busy gone", {31'd0, busy}, 32'd0);
        chk("t1 empty", {31'd0, lifo_empty}, 32'd1);
        chk("t1 pops", pop_cnt - p0, 32'd3);

        // Until-empty drain of 2
        push(8'hA0); push(8'hA1);
        p0 = pop_cnt;
        @(negedge clk); start = 1'b1; count = 5'd0;
        @(negedge clk); start = 1'b0;
        @(negedge clk); #1 chk_word("t2 w0", 8'hA1, 1'b0);
        @(negedge clk); #1 chk_word("t2 w1", 8'hA0, 1'b0);
        @(negedge clk); #1 chk("t2 done", {31'd0, done}, 32'd1);
        chk("t2 drained", {27'd0, drained_count}, 32'd2);
        chk("t2 underrun", {31'd0, underrun}, 32'd0);
        chk("t2 pops", pop_cnt - p0, 32'd2);

        // Counted drain of 4 with only one word stacked
        @(negedge clk);
        push(8'h05);
        p0 = pop_cnt;
        @(negedge clk); start = 1'b1; count = 5'd4;
        @(negedge clk); start = 1'b0;
        @(negedge clk); #1 chk_word("t3 w0", 8'h05, 1'b0);
        chk("t3 w0 pop", {31'd0, lifo_pop}, 32'd0);
        @(negedge clk); #1 chk("t3 done", {31'd0, done}, 32'd1);
        chk("t3 underrun", {31'd0, underrun}, 32'd1);
        chk("t3 drained", {27'd0, drained_count}, 32'd1);
        @(negedge clk); #1 chk("t3 underrun held", {31'd0, underrun}, 32'd1);
        chk("t3 pops", pop_cnt - p0, 32'd1);

        // Counted drain of 2 with 3 cycles of backpressure on the first word
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        p0 = pop_cnt;
        @(negedge clk); start = 1'b1; count = 5'd2; m_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        #1 chk("t4 underrun cleared", {31'd0, underrun}, 32'd0);
        chk("t4 drained cleared", {27'd0, drained_count}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1 chk_word("t4 stall", 8'h04, 1'b0);
            chk("t4 stall pop", {31'd0, lifo_pop}, 32'd0);
        end
        @(negedge clk); m_ready = 1'b1;
        #1 chk_word("t4 w0", 8'h04, 1'b0);
        chk("t4 w0 pop", {31'd0, lifo_pop}, 32'd1);
        @(negedge clk); #1 chk_word("t4 w1", 8'h03, 1'b1);
        @(negedge clk); #1 chk("t4 done", {31'd0, done}, 32'd1);
        chk("t4 drained", {27'd0, drained_count}, 32'd2);
        chk("t4 pops", pop_cnt - p0, 32'd2);
        chk("t4 top left", {24'd0, lifo_rd_data}, 32'h02);

        // Drain the leftovers until empty
        @(negedge clk); start = 1'b1; count = 5'd0;
        @(negedge clk); start = 1'b0;
        @(negedge clk); #1 chk_word("t4b w0", 8'h02, 1'b0);
        @(negedge clk); #1 chk_word("t4b w1", 8'h01, 1'b0);
        @(negedge clk); #1 chk("t4b drained", {27'd0, drained_count}, 32'd2);

        // Empty stack, start retriggered while busy
        @(negedge clk);
        p0 = pop_cnt;
        @(negedge clk); start = 1'b1; count = 5'd0;
        @(negedge clk);
        #1 chk("t5 load pop", {31'd0, lifo_pop}, 32'd0);
        chk("t5 load busy", {31'd0, busy}, 32'd1);
        @(negedge clk); start = 1'b0;
        #1 chk("t5 done", {31'd0, done}, 32'd1);
        chk("t5 valid", {31'd0, m_valid}, 32'd0);
        chk("t5 drained", {27'd0, drained_count}, 32'd0);
        chk("t5 underrun", {31'd0, underrun}, 32'd0);
        @(negedge clk); #1 chk("t5 busy off", {31'd0, busy}, 32'd0);
        @(negedge clk); #1 chk("t5 still idle", {31'd0, busy}, 32'd0);
        chk("t5 no valid", {31'd0, m_valid}, 32'd0);
        chk("t5 pops", pop_cnt - p0, 32'd0);

        // Full-stack counted drain aborted by reset after the 5th handshake
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
        p0 = pop_cnt;
        @(negedge clk); start = 1'b1; count = 5'd16;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1 chk_word("t6 word", 8'h8F - 8'(i), 1'b0);
        end
        @(negedge clk); #1 chk_word("t6 6th word", 8'h8A, 1'b0);
        reset_tmp = 1'b1;
        #1 chk_idle_outputs("t6 async reset");
        chk("t6 pops", pop_cnt - p0, 32'd6);
        chk("t6 top after abort", {24'd0, lifo_rd_data}, 32'h89);
        @(negedge clk); reset_tmp = 1'b0;
        @(negedge clk); start = 1'b1; count = 5'd1;
        @(negedge clk); start = 1'b0;
        #1 chk("t6 restart busy", {31'd0, busy}, 32'd1);
        @(negedge clk); #1 chk_word("t6 restart w0", 8'h89, 1'b1);
        @(negedge clk); #1 chk("t6 restart done", {31'd0, done}, 32'd1);
        chk("t6 restart drained", {27'd0, drained_count}, 32'd1);
        chk("t6 restart underrun", {31'd0, underrun}, 32'd0);

        chk("pop while empty", bad_pops, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
